imul_dot_accum: RTL and testbench
=================================

// Module: imul_dot_accum
// PURPOSE
//  Downstream consumer of the integer multiplier's 32-bit product stream.
//  Accumulates a configured number of consecutive products into one dot-product sum.
//  Emits that sum on a val/rdy output stream.
//  Sits between the multiplier ostream and the result sink.
//  A small config interface sets the vector length before each dot product.
// PARAMETERS
//  p_nbits      32   width of products, accumulator and output sum
//  p_len_nbits  8    width of vector-length field; max length 2^p_len_nbits-1
// PORTS
//  clk          in   1            clock; all state updates on posedge
//  reset        in   1            synchronous, active-high
//  cfg_val      in   1            length config valid
//  cfg_rdy      out  1            block ready to accept a length config
//  cfg_len      in   p_len_nbits  number of products in the next dot product
//  istream_val  in   1            product valid (from multiplier ostream_val)
//  istream_rdy  out  1            product accepted (to multiplier ostream_rdy)
//  istream_msg  in   p_nbits      product value
//  ostream_val  out  1            dot-product sum valid
//  ostream_rdy  in   1            sink ready
//  ostream_msg  out  p_nbits      dot-product sum
//  busy         out  1            high in ACCUM or DONE
// BEHAVIOUR
//  - Reset: clk and reset as decided (reset synchronous, active-high).
//    While reset is high: state<=IDLE, sum<=0, count<=0.
//    All outputs are driven from state; in the cycle after reset they are
//    cfg_rdy=1, istream_rdy=0, ostream_val=0, busy=0, ostream_msg=0.
//  - Handshake: a transfer occurs on any port when val&&rdy at posedge.
//    rdy never depends combinationally on val of the same port.
//  - FSM IDLE: cfg_rdy=1.
//    On cfg fire: sum<=0, count<=cfg_len.
//    Next state is ACCUM if cfg_len!=0, else DONE (sum 0).
//  - FSM ACCUM: istream_rdy=1.
//    On istream fire: sum<=sum+istream_msg (mod 2^p_nbits; carry discarded)
//    and count<=count-1.
//    If count==1 at the fire, next state is DONE.
//    Stalls indefinitely when istream_val=0.
//  - FSM DONE: ostream_val=1 and ostream_msg=sum; istream_rdy=0, cfg_rdy=0.
//    On ostream fire, next state is IDLE.
//    sum is held stable while ostream_val&&!ostream_rdy.
//  - ostream_msg = sum register in all states (equals the final sum only in DONE).
//  - Latency:
//    * last product accepted at edge N -> ostream_val high in cycle N+1;
//    * ostream fire at edge M -> cfg_rdy high in cycle M+1;
//    * minimum cost per dot product is 1 cycle config + L products + 1 output cycle.
//  - Back-to-back operation is allowed: a new cfg_val may already be held
//    high in DONE; it is accepted on the first IDLE cycle.
//  - Products arriving outside ACCUM are not accepted (istream_rdy=0),
//    so no data is lost.
//  - Reset asserted mid-ACCUM or mid-DONE aborts the operation.
//    Any partial sum is discarded and no output is emitted.
//  - Illegal state encoding: next state is IDLE.
// STRUCTURE
//  - Shared package imul_pkg holds the state constants
//    (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the state typedef.
//  - Split into datapath and control:
//    * imul_dot_accum_dpath: sum register with enable and clear mux,
//      adder, down-counter with load; exposes count_is_one and count_is_zero.
//    * Control FSM lives in the top module.
//    * The datapath uses the existing vc register, mux and adder library cells.
//  - Line trace shows cfg, istream and ostream val/rdy/msg, plus the state
//    as I/A/D and the remaining count.
// TESTING
//  1. cfg_len=3; products 2,3,4 with sink ready -> ostream_msg=9,
//     one cycle after the 3rd product is accepted.
//  2. cfg_len=0 -> ostream_msg=0 appears the next cycle;
//     istream_rdy never asserted.
//  3. cfg_len=2; products 0xFFFFFFFF,0x00000002 -> ostream_msg=0x00000001
//     (wrap-around).
//  4. cfg_len=4 with random source/sink delays (0-5 cycles) ->
//     sum correct, ostream_msg stable while stalled, no product dropped.
//  5. Reset mid-ACCUM after 1 of 3 products; then cfg_len=1 with product 7
//     -> ostream_msg=7, no stale output.
//  6. Back-to-back: cfg_len=1 with product 5, then cfg_len=2 with 6,6, and
//     cfg_val held high throughout -> outputs 5 then 12, in order.

Source files
------------

// File: rtl/imul_pkg.sv
// Shared definitions for the integer-multiplier dot-product accumulator.
package imul_pkg;

    localparam int unsigned P_NBITS     = 32;
    localparam int unsigned P_LEN_NBITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/imul_dot_accum_dpath.sv
// Datapath: clearable/enabled sum register with adder, loadable down-counter.
module imul_dot_accum_dpath #(
    parameter int unsigned p_nbits     = 32,
    parameter int unsigned p_len_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sum_clr,
    input  logic                   sum_en,
    input  logic                   cnt_load,
    input  logic                   cnt_dec,
    input  logic [p_len_nbits-1:0] cfg_len,
    input  logic [p_nbits-1:0]     istream_msg,
    output logic [p_nbits-1:0]     sum,
    output logic                   count_is_one,
    output logic                   count_is_zero
);

    logic [p_nbits-1:0]     sum_next;
    logic [p_len_nbits-1:0] count;
    logic [p_len_nbits-1:0] count_next;

    // Carry out of the adder is dropped: the sum wraps modulo 2^p_nbits.
    always_comb begin
        sum_next = sum_clr ? '0 : (sum + istream_msg);
    end

    always_comb begin
        count_next = cnt_load ? cfg_len : (count - p_len_nbits'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (sum_clr || sum_en) begin
            sum <= sum_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (cnt_load || cnt_dec) begin
            count <= count_next;
        end
    end

    assign count_is_one  = (count == p_len_nbits'(1));
    assign count_is_zero = (count == '0);

endmodule

// File: rtl/imul_dot_accum.sv
// Accumulates a configured number of multiplier products into one dot-product sum.
module imul_dot_accum
    import imul_pkg::*;
#(
    parameter int unsigned p_nbits     = P_NBITS,
    parameter int unsigned p_len_nbits = P_LEN_NBITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_val,
    output logic                   cfg_rdy,
    input  logic [p_len_nbits-1:0] cfg_len,
    input  logic                   istream_val,
    output logic                   istream_rdy,
    input  logic [p_nbits-1:0]     istream_msg,
    output logic                   ostream_val,
    input  logic                   ostream_rdy,
    output logic [p_nbits-1:0]     ostream_msg,
    output logic                   busy
);

    state_t state;
    state_t state_next;

    logic sum_clr;
    logic sum_en;
    logic cnt_load;
    logic cnt_dec;
    logic count_is_one;
    logic count_is_zero;

    imul_dot_accum_dpath #(
        .p_nbits     (p_nbits),
        .p_len_nbits (p_len_nbits)
    ) u_dpath (
        .clk           (clk),
        .reset         (reset),
        .sum_clr       (sum_clr),
        .sum_en        (sum_en),
        .cnt_load      (cnt_load),
        .cnt_dec       (cnt_dec),
        .cfg_len       (cfg_len),
        .istream_msg   (istream_msg),
        .sum           (ostream_msg),
        .count_is_one  (count_is_one),
        .count_is_zero (count_is_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready signals depend only on state, never on the same port's valid.
    always_comb begin
        state_next  = state;
        cfg_rdy     = 1'b0;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        sum_clr     = 1'b0;
        sum_en      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state)
            IDLE: begin
                cfg_rdy = 1'b1;
                if (cfg_val) begin
                    sum_clr    = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = (cfg_len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                istream_rdy = 1'b1;
                if (count_is_zero) begin
                    // Unreachable in normal operation; avoids a stuck accumulate.
                    istream_rdy = 1'b0;
                    state_next  = DONE;
                end else if (istream_val) begin
                    sum_en  = 1'b1;
                    cnt_dec = 1'b1;
                    if (count_is_one) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == ACCUM) || (state == DONE);

endmodule

// File: tb/tb_imul_dot_accum.sv
// Self-checking bench for imul_dot_accum: directed and randomized dot products.
module tb_imul_dot_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [7:0]  cfg_len;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] istream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] ostream_msg;
    logic        busy;

    int checks = 0;
    int errors = 0;

    imul_dot_accum dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_val     (cfg_val),
        .cfg_rdy     (cfg_rdy),
        .cfg_len     (cfg_len),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the dot product is the plain sum of the products, modulo 2^32.
    function automatic logic [31:0] ref_sum(input logic [31:0] prods[$]);
        longint unsigned s = 0;
        foreach (prods[i]) s += longint'(prods[i]);
        return s[31:0];
    endfunction

    task automatic send(input logic [31:0] p, input int maxd);
        int d;
        int g;
        d = (maxd > 0) ? int'($urandom_range(maxd, 0)) : 0;
        repeat (d) begin
            check("cfg_rdy_low_in_accum", {31'd0, cfg_rdy}, 32'd0);
            step();
        end
        istream_val = 1'b1;
        istream_msg = p;
        g = 0;
        while (!istream_rdy && g < 50) begin
            step();
            g++;
        end
        check("istream_rdy_timeout", {31'd0, g < 50}, 32'd1);
        step();
        istream_val = 1'b0;
        istream_msg = $urandom;
    endtask

    task automatic recv(input logic [31:0] exp, input int maxd);
        int d;
        check("ostream_val_latency", {31'd0, ostream_val}, 32'd1);
        check("ostream_msg", ostream_msg, exp);
        check("istream_rdy_done", {31'd0, istream_rdy}, 32'd0);
        check("cfg_rdy_done", {31'd0, cfg_rdy}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd1);
        d = (maxd > 0) ? int'($urandom_range(maxd, 0)) : 0;
        ostream_rdy = 1'b0;
        repeat (d) begin
            step();
            check("ostream_val_stall", {31'd0, ostream_val}, 32'd1);
            check("ostream_msg_stall", ostream_msg, exp);
        end
        ostream_rdy = 1'b1;
        step();
        ostream_rdy = 1'b0;
        check("cfg_rdy_after_out", {31'd0, cfg_rdy}, 32'd1);
        check("ostream_val_after_out", {31'd0, ostream_val}, 32'd0);
        check("busy_after_out", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_dot(input logic [31:0] prods[$], input int maxd, input bit hold);
        int g;
        if (hold) check("b2b_first_idle", {31'd0, cfg_rdy}, 32'd1);
        cfg_len = 8'(prods.size());
        cfg_val = 1'b1;
        g = 0;
        while (!cfg_rdy && g < 50) begin
            step();
            g++;
        end
        check("cfg_rdy_timeout", {31'd0, g < 50}, 32'd1);
        step();
        if (!hold) cfg_val = 1'b0;
        if (prods.size() != 0) begin
            check("istream_rdy_accum", {31'd0, istream_rdy}, 32'd1);
            check("busy_accum", {31'd0, busy}, 32'd1);
        end
        foreach (prods[i]) send(prods[i], maxd);
        recv(ref_sum(prods), maxd);
    endtask

    initial begin
        logic [31:0] q[$];
        reset       = 1'b1;
        cfg_val     = 1'b0;
        cfg_len     = '0;
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b0;
        repeat (2) step();
        check("rst_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
        check("rst_istream_rdy", {31'd0, istream_rdy}, 32'd0);
        check("rst_ostream_val", {31'd0, ostream_val}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ostream_msg", ostream_msg, 32'd0);
        reset = 1'b0;
        step();

        // Basic sum.
        q = {32'd2, 32'd3, 32'd4};
        run_dot(q, 0, 1'b0);

        // Zero-length vector goes straight to output with sum 0.
        q = {};
        run_dot(q, 0, 1'b0);

        // Wrap-around.
        q = {32'hFFFF_FFFF, 32'h0000_0002};
        run_dot(q, 0, 1'b0);
        check("wrap_value", ref_sum(q), 32'h0000_0001);

        // Random data with random source/sink delays.
        for (int n = 0; n < 6; n++) begin
            q = {};
            for (int k = 0; k < 4; k++) q.push_back($urandom);
            run_dot(q, 5, 1'b0);
        end
        for (int n = 0; n < 3; n++) begin
            q = {};
            for (int k = 0; k < int'($urandom_range(9, 1)); k++) q.push_back($urandom);
            run_dot(q, 3, 1'b0);
        end

        // Reset mid-accumulate discards the partial sum.
        cfg_len = 8'd3;
        cfg_val = 1'b1;
        step();
        cfg_val = 1'b0;
        send(32'd100, 0);
        check("midreset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        check("midreset_ostream_val", {31'd0, ostream_val}, 32'd0);
        check("midreset_ostream_msg", ostream_msg, 32'd0);
        check("midreset_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
        check("midreset_busy_low", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        q = {32'd7};
        run_dot(q, 0, 1'b0);

        // Back-to-back with cfg_val held high throughout.
        q = {32'd5};
        run_dot(q, 0, 1'b0);
        cfg_val = 1'b1;
        q = {32'd5};
        run_dot(q, 0, 1'b1);
        q = {32'd6, 32'd6};
        run_dot(q, 0, 1'b1);
        cfg_val = 1'b0;
        step();
        check("final_idle", {31'd0, cfg_rdy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
